// File: rtl/sqr_iter_shift_add.sv
// ---------------------------------------------------------------------------
// sqr_iter_shift_add
//   Iterative unsigned squarer. One argument is accepted through a valid/ready
//   handshake, then squared with a shift-add loop that retires one partial
//   product per clock for exactly DATA_WIDTH clocks (zero multiplier bits are
//   not skipped). The 2*DATA_WIDTH result is presented with a one-cycle valid
//   pulse and then held until the next result is loaded.
//
// Handshake: an argument transfers on a rising edge where arg_vld and arg_rdy
//   are both high. arg_rdy is high only while idle; arg_vld seen while busy is
//   dropped, not queued. res_vld is a single-cycle pulse with no back-pressure.
//
// Ports
//   clk        in   1         rising-edge clock
//   rst        in   1         synchronous reset, active-high
//   arg_vld    in   1         argument valid
//   arg        in   W         unsigned argument
//   arg_rdy    out  1         idle, argument can be accepted this cycle
//   res_vld    out  1         one-cycle pulse, res holds arg*arg
//   res        out  2W        square of the last accepted argument
//   dbg_state  out  2         current FSM state (IDLE=0, CALC=1, DONE=2)
// ---------------------------------------------------------------------------
module sqr_iter_shift_add #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arg_vld,
    input  logic [DATA_WIDTH-1:0]     arg,
    output logic                      arg_rdy,
    output logic                      res_vld,
    output logic [2*DATA_WIDTH-1:0]   res,
    output logic [1:0]                dbg_state
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    logic [2*DATA_WIDTH-1:0]   r_mcand;
    logic [DATA_WIDTH-1:0]     r_mplier;
    logic [2*DATA_WIDTH-1:0]   r_acc;
    logic [CW-1:0]             r_cnt;
    logic                      r_arg_rdy;
    logic                      r_res_vld;
    logic [2*DATA_WIDTH-1:0]   r_res;

    logic                      w_accept;
    logic                      w_last;
    logic [2*DATA_WIDTH-1:0]   w_acc_next;

    assign w_accept   = (r_state == ST_IDLE) && arg_vld;
    assign w_last     = (r_state == ST_CALC) && (r_cnt == CNT_LAST);
    // Partial product for this iteration: add the shifted multiplicand when
    // the current multiplier LSB is set. The 2W accumulator cannot overflow.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_CALC;
            ST_CALC: if (w_last)   w_state_next = ST_DONE;
            ST_DONE:               w_state_next = ST_IDLE;
            default:               w_state_next = ST_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_arg_rdy <= 1'b1;
            r_res_vld <= 1'b0;
            r_res     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // Operands are latched here; arg may change freely later.
                        r_mcand   <= {{DATA_WIDTH{1'b0}}, arg};
                        r_mplier  <= arg;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_arg_rdy <= 1'b0;
                    end
                end
                ST_CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_res     <= w_acc_next;
                        r_res_vld <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_res_vld <= 1'b0;
                    r_arg_rdy <= 1'b1;
                end
                default: begin
                    r_res_vld <= 1'b0;
                    r_arg_rdy <= 1'b1;
                end
            endcase
        end
    end

    assign arg_rdy   = r_arg_rdy;
    assign res_vld   = r_res_vld;
    assign res       = r_res;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sqr_iter_shift_add.sv
module tb_sqr_iter_shift_add;

  localparam int W  = 8;
  localparam int RW = 2 * W;

  logic          clk;
  logic          rst;
  logic          arg_vld;
  logic [W-1:0]  arg;
  logic          arg_rdy;
  logic          res_vld;
  logic [RW-1:0] res;
  logic [1:0]    dbg_state;

  int total;
  int bad;
  logic [RW-1:0] exp_q[$];

  sqr_iter_shift_add #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .arg_vld   (arg_vld),
    .arg       (arg),
    .arg_rdy   (arg_rdy),
    .res_vld   (res_vld),
    .res       (res),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] model_sq(input int a);
    int p;
    p = a * a;
    return p[RW-1:0];
  endfunction

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // ---------------- drivers ----------------
  // Present an argument on the first edge with arg_rdy high (bounded), then drop arg_vld.
  task automatic drive_arg(input logic [W-1:0] a);
    int waited;
    waited = 0;
    while (arg_rdy !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    total++;
    if (arg_rdy !== 1'b1) begin
      bad++;
      $display("FAIL drive_wait_rdy: arg_rdy=%b required 1 within 40 cycles", arg_rdy);
    end
    arg_vld = 1'b1;
    arg     = a;
    tick();
    arg_vld = 1'b0;
    arg     = W'($urandom);
  endtask

  // Run n edges, counting result pulses and recording the first one.
  task automatic collect(input int n, output int pulses, output int first_lat,
                         output logic [RW-1:0] first_val);
    pulses    = 0;
    first_lat = -1;
    first_val = '0;
    for (int j = 1; j <= n; j++) begin
      tick();
      if (res_vld === 1'b1) begin
        if (pulses == 0) begin
          first_lat = j;
          first_val = res;
        end
        pulses++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst     = 1'b1;
    arg_vld = 1'b1;  // reset must win over a simultaneous valid
    arg     = 8'd77;
    tick();
    tick();
    total++; if (arg_rdy !== 1'b1)  begin bad++; $display("FAIL reset_rdy: got %b want 1", arg_rdy); end
    total++; if (res_vld !== 1'b0)  begin bad++; $display("FAIL reset_vld: got %b want 0", res_vld); end
    total++; if (res !== '0)        begin bad++; $display("FAIL reset_res: got %0d want 0", res); end
    rst     = 1'b0;
    arg_vld = 1'b0;
    tick();
    total++; if (arg_rdy !== 1'b1)  begin bad++; $display("FAIL reset_nothing_accepted: arg_rdy=%b want 1", arg_rdy); end
  endtask

  task automatic test_basic();
    drive_arg(8'd3);  // edge E0
    total++; if (arg_rdy !== 1'b0) begin bad++; $display("FAIL basic_rdy_E0: got %b want 0", arg_rdy); end
    for (int j = 1; j <= W + 1; j++) begin
      tick();  // edge E0+j
      total++;
      if (res_vld !== (j == W)) begin
        bad++; $display("FAIL basic_vld_e%0d: got %b want %b", j, res_vld, (j == W));
      end
      total++;
      if (arg_rdy !== (j == W + 1)) begin
        bad++; $display("FAIL basic_rdy_e%0d: got %b want %b", j, arg_rdy, (j == W + 1));
      end
      if (j >= W) begin
        total++;
        if (res !== model_sq(3)) begin bad++; $display("FAIL basic_res_e%0d: got %0d want %0d", j, res, model_sq(3)); end
      end
    end
  endtask

  task automatic test_extremes();
    int a_list[7];
    int pulses, lat;
    logic [RW-1:0] val;
    a_list = '{0, 255, 128, 1, 254, 127, 85};
    foreach (a_list[k]) begin
      drive_arg(W'(a_list[k]));
      collect(W + 1, pulses, lat, val);
      total++; if (pulses !== 1) begin bad++; $display("FAIL ext_pulses a=%0d: got %0d want 1", a_list[k], pulses); end
      total++; if (lat !== W) begin bad++; $display("FAIL ext_latency a=%0d: got %0d want %0d", a_list[k], lat, W); end
      total++; if (val !== model_sq(a_list[k])) begin bad++; $display("FAIL ext_res a=%0d: got %0d want %0d", a_list[k], val, model_sq(a_list[k])); end
      // result stays put after the pulse
      repeat (3) tick();
      total++; if (res !== model_sq(a_list[k])) begin bad++; $display("FAIL ext_hold a=%0d: got %0d want %0d", a_list[k], res, model_sq(a_list[k])); end
    end
  endtask

  task automatic test_busy_drop();
    int pulses;
    logic [RW-1:0] val;
    drive_arg(8'd5);
    pulses = 0;
    val    = '0;
    for (int j = 1; j <= W + 1; j++) begin
      arg_vld = (j == 3);  // a valid landing at edge E0+3 must be dropped
      arg     = (j == 3) ? 8'd7 : W'($urandom);
      tick();
      if (res_vld === 1'b1) begin pulses++; val = res; end
    end
    arg_vld = 1'b0;
    repeat (W + 3) begin
      tick();
      if (res_vld === 1'b1) pulses++;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL busy_pulses: got %0d want 1", pulses); end
    total++; if (val !== model_sq(5)) begin bad++; $display("FAIL busy_res: got %0d want %0d", val, model_sq(5)); end
    total++; if (res !== model_sq(5)) begin bad++; $display("FAIL busy_not_squared: got %0d want %0d", res, model_sq(5)); end
  endtask

  task automatic test_back_to_back();
    int lat[$];
    logic [RW-1:0] vals[$];
    arg_vld = 1'b1;
    arg     = 8'd12;
    tick();        // E0
    arg = 8'd13;   // still valid; taken at the next idle edge
    for (int j = 1; j <= 2 * W + 3; j++) begin
      if (j == W + 2) arg_vld = 1'b1;  // held through the second accept
      if (j == W + 3) arg_vld = 1'b0;
      tick();
      if (res_vld === 1'b1) begin lat.push_back(j); vals.push_back(res); end
    end
    arg_vld = 1'b0;
    total++;
    if (lat.size() !== 2) begin
      bad++; $display("FAIL b2b_count: got %0d want 2", lat.size());
    end else begin
      total++; if (lat[0] !== W)         begin bad++; $display("FAIL b2b_lat0: got %0d want %0d", lat[0], W); end
      total++; if (vals[0] !== model_sq(12)) begin bad++; $display("FAIL b2b_res0: got %0d want %0d", vals[0], model_sq(12)); end
      total++; if (lat[1] !== 2 * W + 2) begin bad++; $display("FAIL b2b_lat1: got %0d want %0d", lat[1], 2 * W + 2); end
      total++; if (vals[1] !== model_sq(13)) begin bad++; $display("FAIL b2b_res1: got %0d want %0d", vals[1], model_sq(13)); end
    end
    repeat (2) tick();
  endtask

  task automatic test_abort();
    int pulses, lat;
    logic [RW-1:0] val;
    drive_arg(8'd200);
    repeat (3) tick();   // edges E0+1..E0+3
    rst = 1'b1;
    tick();              // E0+4
    rst = 1'b0;
    total++; if (arg_rdy !== 1'b1) begin bad++; $display("FAIL abort_rdy: got %b want 1", arg_rdy); end
    collect(W + 3, pulses, lat, val);
    total++; if (pulses !== 0) begin bad++; $display("FAIL abort_pulses: got %0d want 0", pulses); end
    total++; if (res !== '0)   begin bad++; $display("FAIL abort_res: got %0d want 0", res); end
    drive_arg(8'd2);
    collect(W + 1, pulses, lat, val);
    total++; if (pulses !== 1 || val !== model_sq(2)) begin bad++; $display("FAIL abort_next: pulses=%0d res=%0d want 1/%0d", pulses, val, model_sq(2)); end
    // abort from DONE: reset on the edge right after the pulse appears
    drive_arg(8'd9);
    repeat (W) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (res_vld !== 1'b0 || res !== '0) begin bad++; $display("FAIL abort_done: vld=%b res=%0d want 0/0", res_vld, res); end
  endtask

  task automatic test_random();
    int pulses, lat;
    logic [RW-1:0] val;
    logic [W-1:0] a;
    for (int n = 0; n < 40; n++) begin
      a = W'($urandom_range(0, (1 << W) - 1));
      repeat ($urandom_range(0, 3)) tick();
      exp_q.push_back(model_sq(int'(a)));
      drive_arg(a);
      collect(W + 1, pulses, lat, val);
      total++;
      if (pulses !== 1 || exp_q.size() == 0) begin
        bad++; $display("FAIL rand_pulses a=%0d: got %0d want 1", a, pulses);
        exp_q.delete();
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        total++; if (val !== e) begin bad++; $display("FAIL rand_res a=%0d: got %0d want %0d", a, val, e); end
      end
    end
  endtask

  task automatic test_sweep();
    int pulses, lat;
    logic [RW-1:0] val;
    for (int a = 0; a < (1 << W); a++) begin
      drive_arg(W'(a));
      collect(W + 1, pulses, lat, val);
      total++; if (pulses !== 1 || val !== model_sq(a)) begin bad++; $display("FAIL sweep a=%0d: pulses=%0d res=%0d want 1/%0d", a, pulses, val, model_sq(a)); end
      total++; if (isqrt(int'(val)) !== a) begin bad++; $display("FAIL sweep_sqrt a=%0d: sqrt(res)=%0d want %0d", a, isqrt(int'(val)), a); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    arg_vld = 1'b0;
    arg     = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_busy_drop();
    test_back_to_back();
    test_abort();
    test_random();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
